// File: rtl/router_ingress.sv
`default_nettype none
// ============================================================================
//  Module      : router_ingress
//  Description : Packet ingress stage of a 3-port router. Decodes the header
//                byte, steers header/payload/parity bytes to one of three
//                output FIFOs, back-pressures the source while the selected
//                FIFO is full, and flags parity or format errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module router_ingress #(
   parameter int MAX_LEN = 63
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [7:0] data_in,
   input  logic       pkt_valid,
   input  logic [2:0] fifo_full,
   output logic       busy,
   output logic       error,
   output logic [7:0] dout,
   output logic [2:0] write_enb
);

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_LOAD_DATA   = 3'd1,
      S_FULL_HOLD   = 3'd2,
      S_LOAD_PARITY = 3'd3,
      S_CHECK       = 3'd4,
      S_DROP        = 3'd5
   } state_t;

   state_t      state_q;
   logic [1:0]  addr_q;
   logic [5:0]  cnt_q;
   logic [7:0]  parity_q;
   logic [7:0]  pbyte_q;
   logic        short_q;
   logic        error_q;
   logic [7:0]  dout_q;
   logic [2:0]  wen_q;

   logic [1:0]  hdr_addr;
   logic [5:0]  hdr_len;
   logic        hdr_bad;
   logic        hdr_full;
   logic        cur_full;
   logic        busy_c;

   // Full flag of the FIFO selected by a 2-bit address; address 3 has no FIFO.
   function automatic logic full_sel(input logic [1:0] a, input logic [2:0] f);
      case (a)
         2'd0:    full_sel = f[0];
         2'd1:    full_sel = f[1];
         2'd2:    full_sel = f[2];
         default: full_sel = 1'b0;
      endcase
   endfunction

   // One-hot write strobe for a FIFO address.
   function automatic logic [2:0] onehot(input logic [1:0] a);
      case (a)
         2'd0:    onehot = 3'b001;
         2'd1:    onehot = 3'b010;
         2'd2:    onehot = 3'b100;
         default: onehot = 3'b000;
      endcase
   endfunction

   // Header decode and back-pressure; busy must react to fifo_full in the same cycle.
   always_comb begin
      hdr_addr = data_in[1:0];
      hdr_len  = data_in[7:2];
      hdr_bad  = (hdr_addr == 2'd3) || (hdr_len == 6'd0) || (int'(hdr_len) > MAX_LEN);
      hdr_full = full_sel(hdr_addr, fifo_full);
      cur_full = full_sel(addr_q, fifo_full);
      busy_c   = 1'b0;
      case (state_q)
         S_IDLE:        busy_c = pkt_valid && (hdr_addr != 2'd3) && hdr_full;
         S_LOAD_DATA:   busy_c = cur_full;
         S_LOAD_PARITY: busy_c = cur_full;
         S_FULL_HOLD:   busy_c = 1'b1;
         S_CHECK:       busy_c = 1'b1;
         S_DROP:        busy_c = 1'b0;
         default:       busy_c = 1'b0;
      endcase
   end

   // Packet FSM: accepts bytes, drives registered FIFO writes and the error flag.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         addr_q   <= 2'd0;
         cnt_q    <= 6'd0;
         parity_q <= 8'h00;
         pbyte_q  <= 8'h00;
         short_q  <= 1'b0;
         error_q  <= 1'b0;
         dout_q   <= 8'h00;
         wen_q    <= 3'b000;
      end else begin
         wen_q <= 3'b000;
         case (state_q)
            S_IDLE: begin
               if (pkt_valid && !busy_c) begin
                  if (hdr_bad) begin
                     error_q <= 1'b1;
                     state_q <= S_DROP;
                  end else begin
                     addr_q   <= hdr_addr;
                     cnt_q    <= hdr_len;
                     parity_q <= data_in;
                     short_q  <= 1'b0;
                     error_q  <= 1'b0;
                     dout_q   <= data_in;
                     wen_q    <= onehot(hdr_addr);
                     state_q  <= S_LOAD_DATA;
                  end
               end
            end
            S_LOAD_DATA: begin
               if (cur_full) begin
                  state_q <= S_FULL_HOLD;
               end else begin
                  dout_q <= data_in;
                  wen_q  <= onehot(addr_q);
                  if (pkt_valid) begin
                     parity_q <= parity_q ^ data_in;
                     cnt_q    <= (cnt_q != 6'd0) ? cnt_q - 6'd1 : 6'd0;
                     if (cnt_q <= 6'd1)
                        state_q <= S_LOAD_PARITY;
                  end else begin
                     // Source ended early: this byte is its parity byte.
                     pbyte_q <= data_in;
                     short_q <= 1'b1;
                     state_q <= S_CHECK;
                  end
               end
            end
            S_FULL_HOLD: begin
               if (!cur_full)
                  state_q <= (cnt_q == 6'd0) ? S_LOAD_PARITY : S_LOAD_DATA;
            end
            S_LOAD_PARITY: begin
               if (cur_full) begin
                  state_q <= S_FULL_HOLD;
               end else begin
                  dout_q  <= data_in;
                  wen_q   <= onehot(addr_q);
                  pbyte_q <= data_in;
                  if (pkt_valid) begin
                     // Packet longer than its header claims.
                     error_q <= 1'b1;
                     state_q <= S_DROP;
                  end else begin
                     state_q <= S_CHECK;
                  end
               end
            end
            S_CHECK: begin
               error_q <= (parity_q != pbyte_q) || short_q;
               state_q <= S_IDLE;
            end
            S_DROP: begin
               if (!pkt_valid)
                  state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy      = busy_c;
   assign error     = error_q;
   assign dout      = dout_q;
   assign write_enb = wen_q;

endmodule
`default_nettype wire

// File: doc/router_ingress.md
ROUTER_INGRESS -- requirements
Module: router_ingress

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: resetn  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have ports: data_in  in  8  packet byte from source.
REQ-004 SHALL have ports: pkt_valid  in  1  high from header through last payload byte; low on parity byte.
REQ-005 SHALL have ports: fifo_full  in  3  full flag of output FIFOs 0..2.
REQ-006 SHALL have ports: busy  out  1  source must hold data_in/pkt_valid while high.
REQ-007 SHALL have ports: error  out  1  last packet failed parity/format check.
REQ-008 SHALL have ports: dout  out  8  byte to FIFOs.
REQ-009 SHALL have ports: write_enb  out  3  one-hot FIFO write strobe.
REQ-010 SHALL have parameter MAX_LEN, default 63, meaning maximum payload bytes.

Function
REQ-011 Packet format SHALL be: header {len[7:2], addr[1:0]}, len payload bytes, one parity byte equal to XOR of header and all payloads.
REQ-012 A byte SHALL be accepted at a rising edge iff busy==0 and the current state expects a byte.
REQ-013 Accepted bytes destined for FIFO SHALL appear on dout with write_enb[addr]=1 exactly one cycle after acceptance; write_enb SHALL be 0 otherwise.
REQ-014 States SHALL be IDLE, LOAD_DATA, FULL_HOLD, LOAD_PARITY, CHECK, DROP.
REQ-015 IDLE: busy=0; on pkt_valid with addr<3 and len!=0, SHALL accept header, latch addr/len, init parity=header, go LOAD_DATA.
REQ-016 IDLE: on pkt_valid with addr<3 and fifo_full[addr]=1, SHALL assert busy, not accept, stay IDLE until full clears.
REQ-017 IDLE: on pkt_valid with addr==3 or len==0, SHALL accept header without writing, set error=1, go DROP.
REQ-018 LOAD_DATA: busy=fifo_full[addr]; each accepted byte SHALL be written, XORed into parity, decrement remaining count; when fifo_full[addr]=1 go FULL_HOLD.
REQ-019 FULL_HOLD: busy=1, no acceptance; when fifo_full[addr]=0 return LOAD_DATA (or LOAD_PARITY if count==0) on next cycle.
REQ-020 After len payloads, SHALL go LOAD_PARITY; parity byte SHALL be accepted and written to FIFO.
REQ-021 pkt_valid low in LOAD_DATA before count==0 SHALL treat that byte as parity (short packet), write it, and force error=1 in CHECK.
REQ-022 pkt_valid high on the byte expected as parity SHALL write it, set error=1, go DROP.
REQ-023 CHECK: busy=1 for exactly one cycle; error SHALL be set to (computed parity != parity byte) OR short flag; then go IDLE.
REQ-024 error SHALL hold its value until the next header is accepted, where it clears to 0.
REQ-025 DROP: busy=0; SHALL accept and discard bytes while pkt_valid=1, plus one byte after pkt_valid falls, then IDLE.
REQ-026 Payload counter SHALL be 6 bits, never wrap; len>MAX_LEN SHALL be treated as format error (REQ-017 path).
REQ-027 fifo_full bits other than fifo_full[addr] SHALL be ignored during a packet.

Reset
REQ-028 resetn low SHALL immediately force state=IDLE, busy=0, error=0, dout=8'h00, write_enb=3'b000, counters and parity=0.
REQ-029 Reset mid-packet SHALL abandon the packet; first pkt_valid after release SHALL be decoded as header.
REQ-030 No output SHALL change on resetn deassertion until the first rising clock edge.

Verification
REQ-031 Header 8'h0D (len 3, addr 1), payloads 11,22,33, parity 8'h0D^11^22^33 -> write_enb=3'b010 for 5 consecutive cycles, error=0.
REQ-032 Same packet with parity byte XOR 8'h01 -> all 5 bytes written, error=1 one cycle after CHECK, cleared on next header.
REQ-033 fifo_full[1]=1 for 4 cycles mid-payload -> busy=1 those cycles plus transition, no write_enb, no byte lost, correct parity.
REQ-034 Header 8'h07 (addr 3) with 1 payload + parity -> write_enb stays 0, error=1, IDLE after parity byte.
REQ-035 pkt_valid drops after 1 of 3 payloads -> third byte written as parity, error=1.
REQ-036 resetn low during payload byte 2 -> outputs zero asynchronously; next packet 8'h04/AA/parity 8'hAE to FIFO 0 passes with error=0.
